// File: rtl/pc_pkg.sv
// Shared types and helpers for the program-counter sequencer and its return-address stack.
package pc_pkg;

    localparam int IMM16_W = 16;
    localparam int IMM26_W = 26;
    localparam int MAX_AW  = 64;

    typedef enum logic [2:0] {
        RK_NONE,
        RK_BRANCH,
        RK_JUMP,
        RK_CALL,
        RK_RET
    } redir_kind_e;

    // Widest supported PC; callers truncate to their own AW.
    function automatic logic [MAX_AW-1:0] sext_imm16(input logic [IMM16_W-1:0] imm);
        return {{(MAX_AW-IMM16_W){imm[IMM16_W-1]}}, imm};
    endfunction

endpackage

// File: rtl/pc_ras.sv
// Circular return-address stack: push when full overwrites the oldest entry,
// pop when empty is ignored (caller falls back to the register target).
module pc_ras
    import pc_pkg::*;
#(
    parameter int W     = 32,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] push_data,
    output logic [W-1:0] top,
    output logic         empty,
    output logic         full
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [W-1:0]  mem_d [DEPTH];
    logic [PW-1:0] ptr_q, ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;

    assign empty = (cnt_q == '0);
    assign full  = (cnt_q == CW'(DEPTH));
    assign top   = mem_q[ptr_q];

    // ptr_q always addresses the newest entry; wrap-around makes the oldest slot the next write.
    always_comb begin
        mem_d = mem_q;
        ptr_d = ptr_q;
        cnt_d = cnt_q;
        if (pop && !empty) begin
            ptr_d = ptr_q - PW'(1);
            cnt_d = cnt_q - CW'(1);
        end else if (push) begin
            ptr_d        = ptr_q + PW'(1);
            mem_d[ptr_d] = push_data;
            if (!full) begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q <= '{default: '0};
            ptr_q <= '0;
            cnt_q <= '0;
        end else begin
            mem_q <= mem_d;
            ptr_q <= ptr_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Program counter owner: sequential fetch, execute-resolved redirects with a stall-safe pending slot.
// Optional return-address stack enabled by defining PC_RAS_EN.
module pc_sequencer
    import pc_pkg::*;
#(
    parameter int            AW        = 32,
    parameter logic [AW-1:0] RESET_PC  = '0,
    parameter int            RAS_DEPTH = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                fetch_ready,
    input  logic                stall,
    input  logic                resolve_valid,
    input  logic [AW-1:0]       resolve_pc,
    input  logic                jump,
    input  logic                jal,
    input  logic                jr,
    input  logic                branch_on_eq,
    input  logic                branch_on_neq,
    input  logic                zero,
    input  logic [IMM16_W-1:0]  immediate16,
    input  logic [IMM26_W-1:0]  immediate26,
    input  logic [AW-1:0]       reg_target,
    output logic [AW-1:0]       pc,
    output logic                pc_valid,
    output logic                pc_src,
    output logic [AW-1:0]       target_address,
    output logic                flush,
    output logic                ras_underflow
);

    redir_kind_e   kind;
    logic [AW-1:0] br_tgt, jmp_tgt, ret_tgt, live_tgt;
    logic [AW-1:0] pc_q, pc_d;
    logic [AW-1:0] pend_tgt_q, pend_tgt_d;
    logic          pend_vld_q, pend_vld_d;
    logic          pc_valid_q, pc_valid_d;
    logic          flush_q, flush_d;
    logic          ufl_q, ufl_d;
    logic          accept, redir_vld;
    logic [AW-1:0] redir_tgt;

    assign br_tgt  = resolve_pc + AW'(1) + AW'(sext_imm16(immediate16));
    assign jmp_tgt = {resolve_pc[AW-1:IMM26_W], immediate26};

`ifdef PC_RAS_EN
    logic          ras_push, ras_pop, ras_empty, ras_full_unused;
    logic [AW-1:0] ras_top;

    // Stack effects follow resolution, not fetch acceptance, so they happen even while stalled.
    assign ras_pop  = resolve_valid & jr;
    assign ras_push = resolve_valid & jal & ~jr;

    pc_ras #(
        .W     (AW),
        .DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (ras_push),
        .pop       (ras_pop),
        .push_data (resolve_pc + AW'(1)),
        .top       (ras_top),
        .empty     (ras_empty),
        .full      (ras_full_unused)
    );

    assign ret_tgt = ras_empty ? reg_target : ras_top;
    assign ufl_d   = ras_pop & ras_empty;
`else
    localparam int RAS_DEPTH_UNUSED = RAS_DEPTH;

    assign ret_tgt = reg_target;
    assign ufl_d   = 1'b0;
`endif

    always_comb begin
        kind = RK_NONE;
        if (resolve_valid) begin
            if (jr)                                                  kind = RK_RET;
            else if (jal)                                            kind = RK_CALL;
            else if (jump)                                           kind = RK_JUMP;
            else if ((branch_on_eq & zero) | (branch_on_neq & ~zero)) kind = RK_BRANCH;
        end
    end

    always_comb begin
        live_tgt = '0;
        case (kind)
            RK_BRANCH:        live_tgt = br_tgt;
            RK_JUMP, RK_CALL: live_tgt = jmp_tgt;
            RK_RET:           live_tgt = ret_tgt;
            default:          live_tgt = '0;
        endcase
    end

    assign pc_src         = (kind != RK_NONE);
    assign target_address = pc_src ? live_tgt : '0;

    // A live redirect beats anything queued while stalled.
    assign redir_vld = pc_src | pend_vld_q;
    assign redir_tgt = pc_src ? live_tgt : pend_tgt_q;

    // The PC only moves once a valid request has been handed to fetch.
    assign accept = pc_valid_q & fetch_ready & ~stall;

    always_comb begin
        pc_d       = pc_q;
        pend_vld_d = pend_vld_q;
        pend_tgt_d = pend_tgt_q;
        flush_d    = 1'b0;
        pc_valid_d = 1'b1;
        if (accept) begin
            pc_d       = redir_vld ? redir_tgt : pc_q + AW'(1);
            flush_d    = redir_vld;
            pend_vld_d = 1'b0;
        end else if (pc_src) begin
            pend_vld_d = 1'b1;
            pend_tgt_d = live_tgt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q       <= RESET_PC;
            pc_valid_q <= 1'b0;
            pend_vld_q <= 1'b0;
            pend_tgt_q <= '0;
            flush_q    <= 1'b0;
            ufl_q      <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            pc_valid_q <= pc_valid_d;
            pend_vld_q <= pend_vld_d;
            pend_tgt_q <= pend_tgt_d;
            flush_q    <= flush_d;
            ufl_q      <= ufl_d;
        end
    end

    assign pc            = pc_q;
    assign pc_valid      = pc_valid_q;
    assign flush         = flush_q;
    assign ras_underflow = ufl_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed and randomized checks of pc_sequencer against a queue-based reference model.
module tb_pc_sequencer;

    localparam int          AW     = 32;
    localparam logic [31:0] RST_PC = 32'h100;
    localparam int          DEPTH  = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        fetch_ready, stall, resolve_valid;
    logic [31:0] resolve_pc, reg_target;
    logic        jump, jal, jr, branch_on_eq, branch_on_neq, zero;
    logic [15:0] immediate16;
    logic [25:0] immediate26;
    logic [31:0] pc, target_address;
    logic        pc_valid, pc_src, flush, ras_underflow;

    pc_sequencer #(
        .AW        (AW),
        .RESET_PC  (RST_PC),
        .RAS_DEPTH (DEPTH)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .fetch_ready    (fetch_ready),
        .stall          (stall),
        .resolve_valid  (resolve_valid),
        .resolve_pc     (resolve_pc),
        .jump           (jump),
        .jal            (jal),
        .jr             (jr),
        .branch_on_eq   (branch_on_eq),
        .branch_on_neq  (branch_on_neq),
        .zero           (zero),
        .immediate16    (immediate16),
        .immediate26    (immediate26),
        .reg_target     (reg_target),
        .pc             (pc),
        .pc_valid       (pc_valid),
        .pc_src         (pc_src),
        .target_address (target_address),
        .flush          (flush),
        .ras_underflow  (ras_underflow)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    // Reference state: fetch PC, queued redirect (at most one, newest wins), return addresses.
    logic [31:0] m_pc;
    bit          m_valid, m_flush, m_uf;
    logic [31:0] m_pend[$];
    logic [31:0] m_ras[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic void mdl_resolve(output bit taken, output logic [31:0] tgt);
        taken = 1'b0;
        tgt   = '0;
        if (!resolve_valid) return;
        if (jr) begin
            taken = 1'b1;
`ifdef PC_RAS_EN
            tgt = (m_ras.size() > 0) ? m_ras[$] : reg_target;
`else
            tgt = reg_target;
`endif
        end else if (jal || jump) begin
            taken = 1'b1;
            tgt   = (resolve_pc & 32'hFC00_0000) | {6'b0, immediate26};
        end else if ((branch_on_eq && zero) || (branch_on_neq && !zero)) begin
            taken = 1'b1;
            tgt   = 32'(longint'(resolve_pc) + 1 + longint'($signed(immediate16)));
        end
    endfunction

    task automatic clear_in();
        fetch_ready   = 1'b1;
        stall         = 1'b0;
        resolve_valid = 1'b0;
        resolve_pc    = '0;
        jump          = 1'b0;
        jal           = 1'b0;
        jr            = 1'b0;
        branch_on_eq  = 1'b0;
        branch_on_neq = 1'b0;
        zero          = 1'b0;
        immediate16   = '0;
        immediate26   = '0;
        reg_target    = '0;
    endtask

    task automatic mdl_reset();
        m_pc    = RST_PC;
        m_valid = 1'b0;
        m_flush = 1'b0;
        m_uf    = 1'b0;
        m_pend.delete();
        m_ras.delete();
    endtask

    // Asynchronous reset pulse placed between clock edges.
    task automatic do_reset();
        rst_n = 1'b0;
        #2;
        chk("rst_pc", pc, RST_PC);
        chk("rst_pc_valid", pc_valid, 0);
        chk("rst_flush", flush, 0);
        chk("rst_ras_underflow", ras_underflow, 0);
        rst_n = 1'b1;
        mdl_reset();
    endtask

    // One clock with the inputs currently driven; checks combinational then registered outputs.
    task automatic step();
        bit          tk;
        logic [31:0] tg;
        bit          acc;
        #1;
        mdl_resolve(tk, tg);
        chk("pc_src", pc_src, tk);
        chk("target_address", target_address, tk ? tg : 32'h0);
        acc    = m_valid && fetch_ready && !stall;
        m_uf   = 1'b0;
        if (acc) begin
            if (tk) begin
                m_pc = tg;  m_flush = 1'b1;
            end else if (m_pend.size() > 0) begin
                m_pc = m_pend[0];  m_flush = 1'b1;
            end else begin
                m_pc = m_pc + 1;  m_flush = 1'b0;
            end
            m_pend.delete();
        end else begin
            m_flush = 1'b0;
            if (tk) begin
                m_pend.delete();
                m_pend.push_back(tg);
            end
        end
        m_valid = 1'b1;
`ifdef PC_RAS_EN
        if (resolve_valid && jr) begin
            if (m_ras.size() > 0) void'(m_ras.pop_back());
            else m_uf = 1'b1;
        end else if (resolve_valid && jal) begin
            m_ras.push_back(resolve_pc + 32'd1);
            if (m_ras.size() > DEPTH) void'(m_ras.pop_front());
        end
`endif
        @(posedge clk);
        #1;
        chk("pc", pc, m_pc);
        chk("pc_valid", pc_valid, m_valid);
        chk("flush", flush, m_flush);
        chk("ras_underflow", ras_underflow, m_uf);
    endtask

    logic [31:0] ret_exp [5];

    initial begin
        clear_in();
        mdl_reset();
        @(posedge clk);
        #1;
        do_reset();

        // Sequential fetch out of reset
        step();
        chk("t1_pc0", pc, 32'h100);
        step();
        step();
        chk("t1_pc2", pc, 32'h102);

        // Conditional branch, taken then not taken
        resolve_valid = 1'b1; resolve_pc = 32'h10; branch_on_eq = 1'b1; zero = 1'b1;
        immediate16 = 16'hFFFC;
        #1;
        chk("t2_br_target", target_address, 32'h0D);
        step();
        chk("t2_br_pc", pc, 32'h0D);
        chk("t2_br_flush", flush, 1);
        zero = 1'b0;
        step();
        clear_in();
        step();

        // Jump keeps upper PC bits; PC wraps from all-ones to zero
        resolve_valid = 1'b1; jump = 1'b1; resolve_pc = 32'hF000_0000; immediate26 = 26'h123;
        step();
        chk("t3_jump_pc", pc, 32'hF000_0123);
        clear_in();
        resolve_valid = 1'b1; jr = 1'b1; reg_target = 32'hFFFF_FFFF;
        step();
        clear_in();
        step();
        chk("t3_wrap_pc", pc, 32'h0);

        // Two redirects under stall, newest wins, single flush on release
        stall = 1'b1; resolve_valid = 1'b1; jump = 1'b1; immediate26 = 26'h40;
        step();
        immediate26 = 26'h80;
        step();
        clear_in();
        stall = 1'b1;
        step();
        stall = 1'b0;
        step();
        chk("t4_pc", pc, 32'h80);
        chk("t4_flush", flush, 1);
        step();
        chk("t4_flush_once", flush, 0);

`ifdef PC_RAS_EN
        // Overfill a depth-4 stack, then drain it past empty
        ret_exp = '{32'h15, 32'h14, 32'h13, 32'h12, 32'hABC};
        for (int i = 0; i < 5; i++) begin
            clear_in();
            resolve_valid = 1'b1; jal = 1'b1; resolve_pc = 32'h10 + i; immediate26 = 26'h200;
            step();
        end
        for (int i = 0; i < 5; i++) begin
            clear_in();
            resolve_valid = 1'b1; jr = 1'b1; reg_target = 32'hABC;
            #1;
            chk("t5_ret_target", target_address, ret_exp[i]);
            step();
        end
        chk("t5_underflow", ras_underflow, 1);
        clear_in();
        step();
`endif

        // Reset while a redirect is pending discards it
        stall = 1'b1; resolve_valid = 1'b1; jump = 1'b1; immediate26 = 26'h40;
        step();
        clear_in();
        do_reset();
        step();
        chk("t6_pc", pc, 32'h100);
        chk("t6_flush", flush, 0);
        step();
        chk("t6_pc_next", pc, 32'h101);

        // Randomized traffic, including simultaneous control flags to exercise priority
        for (int n = 0; n < 400; n++) begin
            clear_in();
            fetch_ready   = ($urandom_range(0, 9) < 8);
            stall         = ($urandom_range(0, 3) == 0);
            resolve_valid = ($urandom_range(0, 9) < 4);
            resolve_pc    = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF0 + $urandom_range(0, 15) : $urandom;
            jr            = ($urandom_range(0, 5) == 0);
            jal           = ($urandom_range(0, 4) == 0);
            jump          = ($urandom_range(0, 4) == 0);
            branch_on_eq  = ($urandom_range(0, 2) == 0);
            branch_on_neq = ($urandom_range(0, 2) == 0);
            zero          = 1'($urandom);
            immediate16   = 16'($urandom);
            immediate26   = 26'($urandom);
            reg_target    = $urandom;
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
